// File: rtl/div_wb_queue.sv
// Write-back queue behind the pipelined signed divider: tags results, applies RISC-V
// divide-by-zero/overflow overrides, buffers them and drains to the CDB. Macro: DIV_WBQ_BYPASS_EN.
module div_wb_queue #(
  parameter int WIDTH     = 32,
  parameter int TAG_WIDTH = 5,
  parameter int DEPTH     = 16,
  parameter int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 issue_valid,
  output logic                 issue_ready,
  input  logic [TAG_WIDTH-1:0] issue_tag,
  input  logic                 issue_is_rem,
  input  logic [WIDTH-1:0]     issue_dividend,
  input  logic [WIDTH-1:0]     issue_divisor,
  input  logic                 div_valid,
  input  logic [TAG_WIDTH-1:0] div_tag,
  input  logic [WIDTH-1:0]     div_quotient,
  input  logic [WIDTH-1:0]     div_remainder,
  output logic                 cdb_valid,
  input  logic                 cdb_ready,
  output logic [TAG_WIDTH-1:0] cdb_tag,
  output logic [WIDTH-1:0]     cdb_data,
  output logic [CNT_W-1:0]     occupancy
);

  localparam int AW      = $clog2(DEPTH);
  localparam int ENTRIES = 1 << TAG_WIDTH;
  localparam logic [WIDTH-1:0] MIN_INT  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  typedef enum logic [1:0] {
    KIND_NORMAL  = 2'd0,
    KIND_DIVZERO = 2'd1,
    KIND_OVF     = 2'd2
  } kind_e;

  // Side table, indexed by ROB tag
  logic [ENTRIES-1:0] tvalid_q;
  logic [ENTRIES-1:0] rem_q;
  kind_e              kind_q [ENTRIES];
  logic [WIDTH-1:0]   dvd_q  [ENTRIES];

  // Result FIFO
  logic [TAG_WIDTH-1:0] tag_mem  [DEPTH];
  logic [WIDTH-1:0]     data_mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CNT_W-1:0]     count;
  logic [CNT_W-1:0]     in_flight;

  logic             accept;
  logic             capture;
  logic             push;
  logic             pop;
  logic             fifo_empty;
  logic             fifo_full;
  kind_e            issue_kind;
  logic [WIDTH-1:0] cap_data;

  assign accept     = issue_valid && issue_ready && !flush;
  assign capture    = div_valid && !flush;
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(DEPTH));
  assign occupancy  = in_flight + count;
  assign issue_ready = (occupancy < CNT_W'(DEPTH));

  always_comb begin
    issue_kind = KIND_NORMAL;
    if (issue_divisor == '0)
      issue_kind = KIND_DIVZERO;
    else if (issue_dividend == MIN_INT && issue_divisor == ALL_ONES)
      issue_kind = KIND_OVF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tvalid_q <= '0;
    end else if (flush) begin
      tvalid_q <= '0;
    end else begin
      if (capture) tvalid_q[div_tag]   <= 1'b0;
      if (accept)  tvalid_q[issue_tag] <= 1'b1;
    end
  end

  // Payload fields are only meaningful while tvalid is set, so they carry no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      rem_q[issue_tag]  <= issue_is_rem;
      kind_q[issue_tag] <= issue_kind;
      dvd_q[issue_tag]  <= issue_dividend;
    end
  end

  always_comb begin
    cap_data = rem_q[div_tag] ? div_remainder : div_quotient;
    case (kind_q[div_tag])
      KIND_DIVZERO: cap_data = rem_q[div_tag] ? dvd_q[div_tag] : ALL_ONES;
      KIND_OVF:     cap_data = rem_q[div_tag] ? '0 : dvd_q[div_tag];
      default:      ;
    endcase
  end

  // CDB handshake: an entry transfers on a cycle where cdb_valid && cdb_ready; while
  // cdb_valid is high and cdb_ready low, cdb_tag/cdb_data hold their value.
`ifdef DIV_WBQ_BYPASS_EN
  logic bypass;
  assign bypass = capture && fifo_empty;
  assign push   = capture && !(bypass && cdb_ready);
  assign pop    = !flush && !fifo_empty && cdb_ready;

  always_comb begin
    cdb_valid = 1'b0;
    cdb_tag   = '0;
    cdb_data  = '0;
    if (!fifo_empty) begin
      cdb_valid = 1'b1;
      cdb_tag   = tag_mem[rd_ptr];
      cdb_data  = data_mem[rd_ptr];
    end else if (bypass) begin
      cdb_valid = 1'b1;
      cdb_tag   = div_tag;
      cdb_data  = cap_data;
    end
  end
`else
  assign push = capture;
  assign pop  = !flush && !fifo_empty && cdb_ready;

  always_comb begin
    cdb_valid = 1'b0;
    cdb_tag   = '0;
    cdb_data  = '0;
    if (!fifo_empty) begin
      cdb_valid = 1'b1;
      cdb_tag   = tag_mem[rd_ptr];
      cdb_data  = data_mem[rd_ptr];
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[wr_ptr]  <= div_tag;
      data_mem[wr_ptr] <= cap_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_flight <= '0;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else if (flush) begin
      in_flight <= '0;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      if (accept && !capture)
        in_flight <= in_flight + CNT_W'(1);
      else if (!accept && capture)
        in_flight <= in_flight - CNT_W'(1);
      if (push && !pop)
        count <= count + CNT_W'(1);
      else if (!push && pop)
        count <= count - CNT_W'(1);
      // DEPTH is a power of two, so pointers wrap naturally
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

`ifndef SYNTHESIS
  a_capture_tag_live: assert property (@(posedge clk) disable iff (!rst_n)
    capture |-> tvalid_q[div_tag])
    else $error("div_wb_queue: result for tag %0d with no outstanding issue", div_tag);

  a_issue_tag_free: assert property (@(posedge clk) disable iff (!rst_n)
    accept |-> !tvalid_q[issue_tag])
    else $error("div_wb_queue: issue to tag %0d that is still outstanding", issue_tag);

  a_push_not_full: assert property (@(posedge clk) disable iff (!rst_n)
    push |-> !fifo_full)
    else $error("div_wb_queue: push into a full result queue");
`endif

endmodule

// File: doc/div_wb_queue.md
Name: div_wb_queue

Overview:
- Sits directly downstream of the pipelined radix-8 signed divider.
- Records per-tag op kind and RISC-V corner-case overrides at issue time.
- Captures the divider's non-stallable result stream and selects quotient or remainder.
- Buffers results in a FIFO and drains them to the CDB with valid/ready; an issue credit guarantees the FIFO never overflows.

Parameters:
- WIDTH, 32, operand/result width
- TAG_WIDTH, 5, ROB tag width; the side table has 2^TAG_WIDTH entries
- DEPTH, 16, result FIFO entries (power of 2, must be >= 2)
- CNT_W, $clog2(DEPTH+1), width of credit/occupancy counters

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous pipeline flush, same cycle the divider is flushed
- issue_valid  in  1  op is being sent to the divider this cycle
- issue_ready  out  1  credit available; upstream may assert issue_valid only when high
- issue_tag  in  TAG_WIDTH  tag of issued op
- issue_is_rem  in  1  0=DIV, 1=REM
- issue_dividend  in  WIDTH  signed dividend
- issue_divisor  in  WIDTH  signed divisor
- div_valid  in  1  divider valid_out
- div_tag  in  TAG_WIDTH  divider tag_out
- div_quotient  in  WIDTH  divider quotient
- div_remainder  in  WIDTH  divider remainder
- cdb_valid  out  1  result available
- cdb_ready  in  1  CDB grant
- cdb_tag  out  TAG_WIDTH  result tag
- cdb_data  out  WIDTH  selected/overridden result
- occupancy  out  CNT_W  in-flight count plus FIFO count

Behaviour:
- Reset (rst_n low, async) and flush (sync):
  - in_flight=0, FIFO pointers/count=0, all side-table valid bits=0.
  - Outputs: cdb_valid=0, cdb_tag=0, cdb_data=0, issue_ready=1, occupancy=0.
  - An issue, div_valid or CDB pop in a flush cycle is discarded.
  - Reset mid-operation loses all results; the divider is reset/flushed by the same event.
- Issue accept = issue_valid && issue_ready. On accept, write table[issue_tag] with:
  - is_rem
  - kind: DIVZERO if divisor==0; else OVF if dividend==MIN_INT && divisor==all-ones; else NORMAL
  - dividend
  - tvalid=1
- Credit:
  - issue_ready = (in_flight + fifo_count) < DEPTH.
  - in_flight increments on accept, decrements on div_valid; simultaneous increment and decrement leaves it unchanged.
  - occupancy = in_flight + fifo_count.
- Capture: on div_valid, look up table[div_tag] and clear its tvalid. Data selection:
  - NORMAL: is_rem ? div_remainder : div_quotient
  - DIVZERO: is_rem ? dividend : all-ones
  - OVF: is_rem ? 0 : dividend (MIN_INT)
  - Push {div_tag, data} into the FIFO. Push is unconditional; the credit makes the full case unreachable.
- Drain: head of FIFO drives cdb_valid/cdb_tag/cdb_data, registered from FIFO storage.
  - Pop when cdb_valid && cdb_ready.
  - cdb_tag/cdb_data hold stable while cdb_valid && !cdb_ready.
  - When empty, cdb_valid=0 and data/tag are 0.
- Latency: div_valid at cycle N -> cdb_valid at N+1 if the FIFO was empty.
- Simultaneous push and pop: count is unchanged; pointers wrap modulo DEPTH.
- Push into an empty FIFO with cdb_ready=1: the entry appears next cycle (no same-cycle pass without the option below).
- Assertions (sim only):
  - div_valid with table[div_tag].tvalid=0 is an error.
  - Issue to a tag whose tvalid=1 is an error.
  - Push while full is an error.

Optional Feature:
- DIV_WBQ_BYPASS_EN defined: when the FIFO is empty and div_valid=1, the selected result drives cdb_* combinationally in the same cycle.
  - If cdb_ready=1 it is consumed and not pushed.
  - Otherwise it is pushed normally.
  - Latency becomes 0 cycles.
- Undefined: no combinational path from div_* to cdb_*; latency is 1 cycle as above.

Test Plan:
- Issue tag 3, DIV, 100/7; div_valid tag 3 q=14 r=2 -> cdb_valid next cycle, tag=3, data=14; with the REM variant data=2.
- Issue tag 5, DIV, -20/0; divider returns garbage -> cdb_data=0xFFFFFFFF; REM variant -> 0xFFFFFFEC (-20).
- Issue tag 6, DIV, 0x80000000/0xFFFFFFFF -> cdb_data=0x80000000; REM variant -> 0.
- Hold cdb_ready=0, issue 16 ops -> issue_ready drops after the 16th accept, occupancy=16; 16 results captured in order; release cdb_ready -> 16 pops in issue order, issue_ready returns high.
- FIFO holds 3 entries, assert flush with div_valid=1 and issue_valid=1 -> next cycle cdb_valid=0, occupancy=0, issue_ready=1.
- Push and pop in the same cycle with the FIFO at count 2 -> count stays 2; run 40 ops to exercise pointer wrap, order preserved.
